rom_stream_reader: RTL and testbench

- Bus-side reader for the 1581 drive ROM (32 KiB, registered read: data valid one clock after addr/oe).
- On a start command it sweeps a contiguous address range and streams the bytes out on a valid/ready byte port, for ROM dump over the host link and boot-time integrity checks.
- Keeps a running 16-bit additive checksum of every delivered byte.

---
 rtl/rom_pkg.sv | 15 +
 rtl/byte_skid_fifo.sv | 53 +++++
 rtl/rom_stream_reader.sv | 133 +++++++++++++
 tb/tb_rom_stream_reader.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_pkg.sv
// Shared constants and types for the 1581 drive ROM stream reader.
package rom_pkg;

    localparam int ROM_ADDR_W = 15;
    localparam int ROM_SIZE   = 1 << ROM_ADDR_W;
    localparam int CSUM_W     = 16;
    localparam int PAYLOAD_W  = 9;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

endpackage

// File: rtl/byte_skid_fifo.sv
// Two-entry FIFO carrying {last, data} between the ROM read port and the byte stream.
module byte_skid_fifo
    import rom_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [PAYLOAD_W-1:0] push_data,
    input  logic                 pop,
    output logic [PAYLOAD_W-1:0] pop_data,
    output logic                 full,
    output logic                 empty,
    output logic [1:0]           count
);

    logic [PAYLOAD_W-1:0] mem_q [2];
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [1:0]           count_q, count_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = ~wr_ptr_q;
        if (pop)  rd_ptr_d = ~rd_ptr_q;
        count_d = count_q + 2'(push) - 2'(pop);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = (count_q == 2'd2);
    assign empty    = (count_q == 2'd0);
    assign count    = count_q;

endmodule

// File: rtl/rom_stream_reader.sv
// Sweeps a contiguous ROM address range and streams the bytes on a valid/ready port,
// keeping a 16-bit additive checksum of every delivered byte.
module rom_stream_reader
    import rom_pkg::*;
#(
    parameter int ADDR_W    = ROM_ADDR_W,
    parameter int CNT_W     = 16,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  byte_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_oe,
    input  logic [7:0]        rom_data,
    output logic              m_valid,
    output logic [7:0]        m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic [CSUM_W-1:0] checksum
);

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    addr_ptr_q, addr_ptr_d;
    logic [CNT_W-1:0]     issue_left_q, issue_left_d;
    logic                 pending_q, pending_d;
    logic                 pending_last_q, pending_last_d;
    logic [CSUM_W-1:0]    checksum_q, checksum_d;
    logic                 done_q, done_d;

    logic [1:0]           fifo_count;
    logic                 fifo_full, fifo_empty;
    logic [PAYLOAD_W-1:0] head;
    logic                 pop, issue;

    byte_skid_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pending_q),
        .push_data ({pending_last_q, rom_data}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign pop = m_valid && m_ready;

    // A read goes out only if it still fits once this cycle's pop and the read already in flight land.
    assign issue = (state_q == RUN) && (issue_left_q != '0) &&
                   ((int'(fifo_count) + int'(pending_q) - int'(pop)) < BUF_DEPTH);

    always_comb begin
        state_d        = state_q;
        addr_ptr_d     = addr_ptr_q;
        issue_left_d   = issue_left_q;
        pending_d      = issue;
        pending_last_d = issue && (issue_left_q == CNT_W'(1));
        checksum_d     = checksum_q;
        done_d         = 1'b0;

        if (pop) checksum_d = checksum_q + CSUM_W'(m_data);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    checksum_d = '0;
                    if (byte_count != '0) begin
                        state_d      = RUN;
                        addr_ptr_d   = base_addr;
                        issue_left_d = byte_count;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    addr_ptr_d   = addr_ptr_q + ADDR_W'(1);
                    issue_left_d = issue_left_q - CNT_W'(1);
                    if (issue_left_q == CNT_W'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && m_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            addr_ptr_q     <= '0;
            issue_left_q   <= '0;
            pending_q      <= 1'b0;
            pending_last_q <= 1'b0;
            checksum_q     <= '0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_ptr_q     <= addr_ptr_d;
            issue_left_q   <= issue_left_d;
            pending_q      <= pending_d;
            pending_last_q <= pending_last_d;
            checksum_q     <= checksum_d;
            done_q         <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign rom_oe   = issue;
    assign rom_addr = addr_ptr_q;
    assign m_valid  = !fifo_empty;
    assign m_data   = fifo_empty ? 8'h00 : head[7:0];
    assign m_last   = !fifo_empty && head[8];
    assign checksum = checksum_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_full && pending_q && !pop));
    a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
        (start && state_q == IDLE) |-> (byte_count <= CNT_W'(ROM_SIZE)));

endmodule

// File: tb/tb_rom_stream_reader.sv
// Bench for rom_stream_reader: a registered-read ROM model, a queue-based stream model
// checked every cycle, and directed transfers with hand-computed checksums.
module tb_rom_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [14:0] base_addr = '0;
    logic [15:0] byte_count = '0;
    logic        busy, done, rom_oe, m_valid, m_last;
    logic [14:0] rom_addr;
    logic [7:0]  rom_data, m_data;
    logic        m_ready = 1'b1;
    logic [15:0] checksum;

    always #5 clk = ~clk;

    rom_stream_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .byte_count (byte_count),
        .busy       (busy),
        .done       (done),
        .rom_addr   (rom_addr),
        .rom_oe     (rom_oe),
        .rom_data   (rom_data),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .checksum   (checksum)
    );

    // ROM contents: byte(a) = (7a + (a >> 8) + 3) mod 256.
    logic [7:0] rom_mem [32768];
    logic [7:0] rom_q = 8'h00;
    logic       rom_vld = 1'b0;

    function automatic logic [7:0] rom_fn(input int a);
        return 8'((a * 7 + (a >> 8) + 3) & 255);
    endfunction

    always @(posedge clk) begin
        rom_vld <= rom_oe;
        if (rom_oe) rom_q <= rom_mem[rom_addr];
    end
    // Garbage outside the valid data cycle so a mistimed capture shows up.
    assign rom_data = rom_vld ? rom_q : 8'hEE;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream model: what must come out, in which order, and what the checksum must read.
    logic [7:0]  exp_q [$];
    logic [14:0] nxt_addr = '0;
    int          iss_left = 0;
    int          issued = 0;
    int          delivered = 0;
    bit          mdl_busy = 1'b0;
    bit          exp_done = 1'b0;
    bit          chk_rst = 1'b1;
    bit          stall_prev = 1'b0;
    logic [7:0]  prev_data = '0;
    logic [15:0] sum = '0;

    always @(negedge clk) begin : model
        bit         was_busy;
        bit         nx_done;
        logic [7:0] eb;
        was_busy = mdl_busy;
        nx_done  = 1'b0;

        if (chk_rst) begin
            check("rst_rom_oe", rom_oe, 0);
            check("rst_rom_addr", rom_addr, 0);
            check("rst_m_valid", m_valid, 0);
            check("rst_m_data", m_data, 0);
            check("rst_m_last", m_last, 0);
            chk_rst = 1'b0;
        end
        check("busy", busy, mdl_busy);
        check("done", done, exp_done);
        check("checksum", checksum, sum);

        if (rom_oe) begin
            if (!mdl_busy || iss_left == 0) begin
                check("oe_unexpected", rom_oe, 0);
            end else begin
                check("rom_addr", rom_addr, nxt_addr);
                nxt_addr = nxt_addr + 15'd1;
                iss_left--;
                issued++;
            end
        end

        if (stall_prev) begin
            check("stall_valid", m_valid, 1);
            check("stall_data", m_data, prev_data);
        end

        if (m_valid && exp_q.size() == 0) begin
            check("valid_unexpected", m_valid, 0);
        end else if (m_valid && m_ready) begin
            eb = exp_q.pop_front();
            check("m_data", m_data, eb);
            check("m_last", m_last, (exp_q.size() == 0));
            sum = sum + 16'(eb);
            delivered++;
            if (exp_q.size() == 0) begin
                mdl_busy = 1'b0;
                nx_done  = 1'b1;
            end
        end

        if (mdl_busy) check("outstanding", (issued - delivered <= 2), 1);

        stall_prev = m_valid && !m_ready;
        prev_data  = m_data;

        if (start && !was_busy) begin
            sum = '0;
            issued = 0;
            delivered = 0;
            exp_q.delete();
            if (byte_count == 16'd0) begin
                nx_done = 1'b1;
            end else begin
                mdl_busy = 1'b1;
                nxt_addr = base_addr;
                iss_left = int'(byte_count);
                for (int i = 0; i < int'(byte_count); i++)
                    exp_q.push_back(rom_mem[(int'(base_addr) + i) % 32768]);
            end
        end

        if (!rst_n) begin
            mdl_busy   = 1'b0;
            nx_done    = 1'b0;
            chk_rst    = 1'b1;
            stall_prev = 1'b0;
            sum        = '0;
            iss_left   = 0;
            exp_q.delete();
        end
        exp_done = nx_done;
    end

    int ready_mode = 0;
    int cyc = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = (cyc % 3 == 0);
            default: m_ready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic start_xfer(input logic [14:0] b, input logic [15:0] c);
        base_addr  = b;
        byte_count = c;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        do begin
            tick();
            @(negedge clk);
            n++;
        end while (!done && n < budget);
        if (!done) check("done_timeout", done, 1);
    endtask

    logic [15:0] whole_sum = '0;

    initial begin
        for (int a = 0; a < 32768; a++) rom_mem[a] = rom_fn(a);
        for (int a = 0; a < 32768; a++) whole_sum = whole_sum + 16'(rom_mem[a]);

        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Four bytes from 0: ROM[0..3] = 3,10,17,24; checksum 0x36.
        start_xfer(15'h0000, 16'd4);
        @(negedge clk);
        check("t1_first_oe", rom_oe, 1);
        check("t1_first_addr", rom_addr, 15'h0000);
        tick();
        @(negedge clk);
        check("t1_not_yet_valid", m_valid, 0);
        tick();
        @(negedge clk);
        check("t1_first_valid", m_valid, 1);
        check("t1_first_byte", m_data, 8'h03);
        wait_done(50);
        check("t1_sum", checksum, 16'h0036);

        // Wrap: 0x7FFE,0x7FFF,0,1 -> 0x74,0x7B,0x03,0x0A; checksum 0xFC.
        start_xfer(15'h7FFE, 16'd4);
        wait_done(50);
        check("t2_sum", checksum, 16'h00FC);

        // Backpressure pattern 1,0,0.
        ready_mode = 1;
        start_xfer(15'h0040, 16'd8);
        wait_done(200);
        ready_mode = 0;

        // Zero-length start: done next cycle, checksum cleared, no reads.
        start_xfer(15'h0500, 16'd0);
        @(negedge clk);
        check("t4_done", done, 1);
        check("t4_sum", checksum, 16'h0000);
        check("t4_busy", busy, 0);

        // A start while busy must be ignored.
        start_xfer(15'h0010, 16'd4);
        tick();
        base_addr  = 15'h7000;
        byte_count = 16'd0;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        wait_done(50);
        repeat (6) begin
            tick();
            @(negedge clk);
        end

        // Reset in the middle of a 16-byte transfer, then a fresh transfer.
        start_xfer(15'h0100, 16'd16);
        for (int n = 0; n < 100 && delivered < 5; n++) begin
            tick();
            @(negedge clk);
        end
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_valid", m_valid, 0);
        check("t5_rst_sum", checksum, 16'h0000);
        repeat (4) begin
            tick();
            @(negedge clk);
        end
        // ROM[0x200..0x203] = 5,12,19,26; checksum 0x3E.
        start_xfer(15'h0200, 16'd4);
        wait_done(50);
        check("t5_sum", checksum, 16'h003E);

        // Full wrapped sweep under random backpressure.
        ready_mode = 2;
        start_xfer(15'h1234, 16'h8000);
        wait_done(80000);
        check("t6_sum", checksum, whole_sum);
        check("t6_count", delivered, 32768);
        ready_mode = 0;
        repeat (4) begin
            tick();
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
